cpu_run_ctrl: RTL and testbench

Run sequencer for the single-cycle RISC-V core. It streams a program from a host into instruction memory and holds the core in reset while loading. It then releases the core and watches the data-memory write bus for a store to a mailbox address, which ends the run. On that store it captures the stored word as the result, reports the cycle count, and parks the core back in reset; a watchdog stops a run that never reaches the mailbox.

---
 rtl/cpu_run_ctrl.sv | 131 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the single-cycle RISC-V core: streams a host program into
// instruction memory, runs the core until a mailbox store or watchdog expiry.
module cpu_run_ctrl #(
  parameter int unsigned IMEM_AW   = 9,
  parameter logic [31:0] DONE_ADDR = 32'h0200_0000,
  parameter logic [23:0] TIMEOUT   = 24'd1_000_000
) (
  input  logic               adc_sck,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [31:0]        load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               start,
  input  logic               abort,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_reset,
  input  logic               cpu_MemWrite,
  input  logic [31:0]        cpu_WrAddr,
  input  logic [31:0]        cpu_WrData,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        result,
  output logic [23:0]        cycles
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [IMEM_AW:0] WCNT_ONE = {{IMEM_AW{1'b0}}, 1'b1};
  localparam logic [IMEM_AW:0] DEPTH    = WCNT_ONE << IMEM_AW;

  state_e               state_q;
  logic                 loaded_q;
  logic [IMEM_AW:0]     wcnt_q;
  logic                 imem_we_q;
  logic [IMEM_AW-1:0]   imem_waddr_q;
  logic [31:0]          imem_wdata_q;
  logic                 cpu_reset_q;
  logic [31:0]          result_q;
  logic [23:0]          cycles_q;

  logic                 accept;
  logic [IMEM_AW:0]     wbase_d;
  logic [IMEM_AW:0]     wcnt_d;
  logic                 overflow_d;
  logic                 mailbox_hit;
  logic [23:0]          cycles_d;
  logic                 timeout_hit;
  logic                 start_ok;

  always_comb begin
    load_ready  = (state_q != ST_RUN);
    accept      = load_valid && load_ready;
    // A word outside LOAD always begins a fresh program at address 0.
    wbase_d     = (state_q == ST_LOAD) ? wcnt_q : '0;
    wcnt_d      = wbase_d + WCNT_ONE;
    overflow_d  = !load_last && (wcnt_d == DEPTH);
    mailbox_hit = cpu_MemWrite && (cpu_WrAddr == DONE_ADDR);
    cycles_d    = cycles_q + 24'd1;
    timeout_hit = (cycles_d == TIMEOUT);
    start_ok    = start && (((state_q == ST_IDLE) && loaded_q) || (state_q == ST_DONE));
  end

  always_ff @(posedge adc_sck or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      loaded_q     <= 1'b0;
      wcnt_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      result_q     <= '0;
      cycles_q     <= '0;
    end else begin
      imem_we_q <= 1'b0;
      if (abort) begin
        state_q     <= ST_IDLE;
        cpu_reset_q <= 1'b1;
      end else if (accept) begin
        imem_we_q    <= 1'b1;
        imem_waddr_q <= wbase_d[IMEM_AW-1:0];
        imem_wdata_q <= load_data;
        wcnt_q       <= wcnt_d;
        cpu_reset_q  <= 1'b1;
        if (load_last) begin
          loaded_q <= 1'b1;
          state_q  <= ST_IDLE;
        end else begin
          loaded_q <= 1'b0;
          state_q  <= overflow_d ? ST_ERR : ST_LOAD;
        end
      end else if (start_ok) begin
        state_q     <= ST_RUN;
        cpu_reset_q <= 1'b0;
        cycles_q    <= '0;
      end else if (state_q == ST_RUN) begin
        cycles_q <= cycles_d;
        // Mailbox store outranks a coincident watchdog expiry.
        if (mailbox_hit) begin
          result_q    <= cpu_WrData;
          state_q     <= ST_DONE;
          cpu_reset_q <= 1'b1;
        end else if (timeout_hit) begin
          state_q     <= ST_ERR;
          cpu_reset_q <= 1'b1;
        end
      end
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign result     = result_q;
  assign cycles     = cycles_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the run sequencer.
module tb_cpu_run_ctrl;

  localparam int unsigned AW    = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] MAILBOX = 32'h0200_0000;
  localparam int          TMO   = 16;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3, M_ERR = 4;

  logic          adc_sck = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_ready;
  logic          start;
  logic          abort;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          cpu_MemWrite;
  logic [31:0]   cpu_WrAddr;
  logic [31:0]   cpu_WrData;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   result;
  logic [23:0]   cycles;

  int n_total = 0;
  int n_bad   = 0;

  // behavioural model
  int          m_st;
  bit          m_loaded;
  int          m_next;
  bit          m_cr;
  bit          m_we;
  int          m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_res;
  int          m_cyc;

  cpu_run_ctrl #(
    .IMEM_AW  (AW),
    .DONE_ADDR(MAILBOX),
    .TIMEOUT  (24'(TMO))
  ) dut (
    .adc_sck     (adc_sck),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .start       (start),
    .abort       (abort),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .cpu_reset   (cpu_reset),
    .cpu_MemWrite(cpu_MemWrite),
    .cpu_WrAddr  (cpu_WrAddr),
    .cpu_WrData  (cpu_WrData),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .result      (result),
    .cycles      (cycles)
  );

  always #160 adc_sck = ~adc_sck;

  task automatic model_reset();
    m_st = M_IDLE; m_loaded = 0; m_next = 0; m_cr = 1; m_we = 0;
    m_waddr = 0; m_wdata = '0; m_res = '0; m_cyc = 0;
  endtask

  task automatic model_update();
    int a;
    m_we = 0;
    if (abort) begin
      m_st = M_IDLE; m_cr = 1;
    end else if (load_valid && m_st != M_RUN) begin
      a = (m_st == M_LOAD) ? m_next : 0;
      m_we = 1; m_waddr = a; m_wdata = load_data; m_next = a + 1; m_cr = 1;
      if (load_last) begin
        m_loaded = 1; m_st = M_IDLE;
      end else begin
        m_loaded = 0; m_st = (a == DEPTH - 1) ? M_ERR : M_LOAD;
      end
    end else if (start && ((m_st == M_IDLE && m_loaded) || m_st == M_DONE)) begin
      m_st = M_RUN; m_cr = 0; m_cyc = 0;
    end else if (m_st == M_RUN) begin
      m_cyc = m_cyc + 1;
      if (cpu_MemWrite && cpu_WrAddr == MAILBOX) begin
        m_res = cpu_WrData; m_st = M_DONE; m_cr = 1;
      end else if (m_cyc == TMO) begin
        m_st = M_ERR; m_cr = 1;
      end
    end
  endtask

  task automatic idle_inputs();
    load_valid = 0; load_data = '0; load_last = 0; start = 0; abort = 0;
    cpu_MemWrite = 0; cpu_WrAddr = '0; cpu_WrData = '0;
  endtask

  task automatic step();
    model_update();
    @(posedge adc_sck);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    model_reset();
    @(posedge adc_sck);
    #1;
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({busy, done, err, load_ready, cpu_reset, imem_we} !== 6'b000110) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000110", {busy, done, err, load_ready, cpu_reset, imem_we});
    end
    n_total++;
    if ({imem_waddr, imem_wdata, result, cycles} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got waddr=%h wdata=%h result=%h cycles=%0d want all zero",
               imem_waddr, imem_wdata, result, cycles);
    end
  endtask

  task automatic test_program_load();
    logic [31:0] prog [3];
    prog[0] = 32'h0050_0093; prog[1] = 32'h0200_0137; prog[2] = 32'h0011_2023;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_data = prog[i]; load_last = (i == 2);
      step();
      n_total++;
      if (imem_we !== 1'b1 || imem_waddr !== AW'(i) || imem_wdata !== prog[i] || cpu_reset !== 1'b1) begin
        n_bad++;
        $display("FAIL load_word%0d: got we=%b addr=%0d data=%h crst=%b want we=1 addr=%0d data=%h crst=1",
                 i, imem_we, imem_waddr, imem_wdata, cpu_reset, i, prog[i]);
      end
    end
    idle_inputs();
    step();
    n_total++;
    if ({imem_we, busy, done, err, load_ready, cpu_reset} !== 6'b000011) begin
      n_bad++;
      $display("FAIL load_end: got %b want 000011", {imem_we, busy, done, err, load_ready, cpu_reset});
    end
  endtask

  task automatic test_normal_run();
    start = 1;
    step();
    start = 0;
    n_total++;
    if (busy !== 1'b1 || cpu_reset !== 1'b0 || cycles !== 24'd0 || load_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL run_start: got busy=%b crst=%b cycles=%0d ready=%b want 1 0 0 0",
               busy, cpu_reset, cycles, load_ready);
    end
    // near-miss address, then strobe-less mailbox address, then the real store
    cpu_MemWrite = 1; cpu_WrAddr = MAILBOX | 32'h4; cpu_WrData = 32'd9;
    step();
    cpu_MemWrite = 0; cpu_WrAddr = MAILBOX;
    step();
    cpu_MemWrite = 1; cpu_WrAddr = MAILBOX; cpu_WrData = 32'd5;
    step();
    idle_inputs();
    n_total++;
    if (result !== 32'd5 || cycles !== 24'd3 || done !== 1'b1 || cpu_reset !== 1'b1 ||
        load_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL run_done: got result=%0d cycles=%0d done=%b crst=%b ready=%b busy=%b want 5 3 1 1 1 0",
               result, cycles, done, cpu_reset, load_ready, busy);
    end
  endtask

  task automatic test_start_ignored();
    do_reset();
    start = 1;
    step();
    n_total++;
    if (busy !== 1'b0 || cpu_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL start_unloaded: got busy=%b crst=%b want 0 1", busy, cpu_reset);
    end
    start = 0; load_valid = 1; load_data = 32'h1111_0000; load_last = 0;
    step();
    load_valid = 0; start = 1;
    step();
    n_total++;
    if (busy !== 1'b0 || cpu_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL start_in_load: got busy=%b crst=%b want 0 1", busy, cpu_reset);
    end
    start = 0; load_valid = 1; load_data = 32'h2222_0001; load_last = 1;
    step();
    idle_inputs();
    n_total++;
    if (imem_waddr !== AW'(1) || imem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL load_continues: got addr=%0d we=%b want 1 1", imem_waddr, imem_we);
    end
  endtask

  task automatic test_timeout();
    start = 1;
    step();
    start = 0;
    for (int i = 1; i < TMO; i++) step();
    n_total++;
    if (busy !== 1'b1 || cycles !== 24'(TMO - 1)) begin
      n_bad++;
      $display("FAIL timeout_early: got busy=%b cycles=%0d want 1 %0d", busy, cycles, TMO - 1);
    end
    step();
    n_total++;
    if (err !== 1'b1 || cycles !== 24'(TMO) || cpu_reset !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_err: got err=%b cycles=%0d crst=%b busy=%b want 1 %0d 1 0",
               err, cycles, cpu_reset, busy, TMO);
    end
    load_valid = 1; load_data = 32'hCAFE_0000; load_last = 0;
    step();
    n_total++;
    if (err !== 1'b0 || imem_we !== 1'b1 || imem_waddr !== '0 || load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL err_reload: got err=%b we=%b addr=%0d ready=%b want 0 1 0 1",
               err, imem_we, imem_waddr, load_ready);
    end
    load_data = 32'hCAFE_0001; load_last = 1;
    step();
    idle_inputs();
  endtask

  task automatic test_collisions();
    start = 1;
    step();
    start = 0;
    for (int i = 1; i < TMO; i++) step();
    cpu_MemWrite = 1; cpu_WrAddr = MAILBOX; cpu_WrData = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    n_total++;
    if (done !== 1'b1 || err !== 1'b0 || cycles !== 24'(TMO) || result !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL mailbox_vs_timeout: got done=%b err=%b cycles=%0d result=%h want 1 0 %0d deadbeef",
               done, err, cycles, result, TMO);
    end
    abort = 1;
    step();
    abort = 0; start = 1; load_valid = 1; load_data = 32'h0BAD_F00D; load_last = 0;
    step();
    n_total++;
    if (busy !== 1'b0 || imem_we !== 1'b1 || imem_waddr !== '0 || cpu_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL start_vs_load: got busy=%b we=%b addr=%0d crst=%b want 0 1 0 1",
               busy, imem_we, imem_waddr, cpu_reset);
    end
    start = 0; load_data = 32'h0BAD_F00E; load_last = 1;
    step();
    idle_inputs();
  endtask

  task automatic test_abort();
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 3; i++) step();
    abort = 1;
    step();
    abort = 0;
    n_total++;
    if (busy !== 1'b0 || cpu_reset !== 1'b1 || result !== 32'hDEAD_BEEF || done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_run: got busy=%b crst=%b result=%h done=%b want 0 1 deadbeef 0",
               busy, cpu_reset, result, done);
    end
    start = 1;
    step();
    start = 0;
    n_total++;
    if (busy !== 1'b1 || cycles !== 24'd0 || cpu_reset !== 1'b0) begin
      n_bad++;
      $display("FAIL rerun_after_abort: got busy=%b cycles=%0d crst=%b want 1 0 0", busy, cycles, cpu_reset);
    end
    step();
    step();
    cpu_MemWrite = 1; cpu_WrAddr = MAILBOX; cpu_WrData = 32'h0000_00A5;
    step();
    idle_inputs();
    n_total++;
    if (done !== 1'b1 || cycles !== 24'd3 || result !== 32'h0000_00A5) begin
      n_bad++;
      $display("FAIL rerun_done: got done=%b cycles=%0d result=%h want 1 3 a5", done, cycles, result);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1; load_data = 32'h5000_0000 + 32'(i); load_last = 0;
      step();
      n_total++;
      if (err !== (i == DEPTH - 1) || imem_waddr !== AW'(i) || imem_we !== 1'b1) begin
        n_bad++;
        $display("FAIL overflow_w%0d: got err=%b addr=%0d we=%b want %b %0d 1",
                 i, err, imem_waddr, imem_we, (i == DEPTH - 1), i);
      end
    end
    load_valid = 0; start = 1;
    step();
    start = 0;
    n_total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL start_in_err: got err=%b busy=%b want 1 0", err, busy);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_valid = 1; load_data = 32'h0000_006F; load_last = 1;
    step();
    load_valid = 0; load_last = 0; start = 1;
    step();
    start = 0;
    step();
    step();
    #50;
    reset = 0;
    model_reset();
    #1;
    n_total++;
    if ({busy, done, err, load_ready, cpu_reset, imem_we} !== 6'b000110 ||
        {imem_waddr, imem_wdata, result, cycles} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got flags=%b waddr=%h wdata=%h result=%h cycles=%0d want 000110 and zeros",
               {busy, done, err, load_ready, cpu_reset, imem_we}, imem_waddr, imem_wdata, result, cycles);
    end
    #50;
    reset = 1;
    start = 1;
    step();
    start = 0;
    n_total++;
    if (busy !== 1'b0 || cpu_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_clears_loaded: got busy=%b crst=%b want 0 1", busy, cpu_reset);
    end
  endtask

  task automatic test_random();
    logic [95:0] act, exp;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      load_valid   = ($urandom_range(99) < 30);
      load_data    = $urandom;
      load_last    = ($urandom_range(99) < 25);
      start        = ($urandom_range(99) < 30);
      abort        = ($urandom_range(99) < 3);
      cpu_MemWrite = ($urandom_range(99) < 20);
      cpu_WrAddr   = ($urandom_range(1) == 0) ? MAILBOX : (MAILBOX ^ (32'h1 << $urandom_range(31)));
      cpu_WrData   = $urandom;
      step();
      exp = {m_st == M_RUN, m_st == M_DONE, m_st == M_ERR, m_st != M_RUN, m_cr, m_we,
             AW'(m_waddr), m_wdata, m_res, 24'(m_cyc)};
      act = {busy, done, err, load_ready, cpu_reset, imem_we, imem_waddr, imem_wdata, result, cycles};
      n_total++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got %h want %h", n, act, exp);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    #10;
    test_reset();
    test_program_load();
    test_normal_run();
    test_start_ignored();
    test_timeout();
    test_collisions();
    test_abort();
    test_overflow();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
